// File: rtl/digit_serial_add_sub_if.sv
// Operand/result digit streams of the digit-serial adder/subtractor.
interface digit_serial_add_sub_if #(
    parameter int unsigned DIGIT_W = 4
);
    logic               in_valid;
    logic               in_first;
    logic               in_last;
    logic               in_sub;
    logic [DIGIT_W-1:0] in_a;
    logic [DIGIT_W-1:0] in_b;
    logic               out_valid;
    logic               out_last;
    logic [DIGIT_W-1:0] out_sum;
    logic               out_carry;
    logic               out_ovf;
    logic               out_err;

    modport master (
        output in_valid, in_first, in_last, in_sub, in_a, in_b,
        input  out_valid, out_last, out_sum, out_carry, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_first, in_last, in_sub, in_a, in_b,
        output out_valid, out_last, out_sum, out_carry, out_ovf, out_err
    );
endinterface

// File: rtl/digit_serial_add_sub.sv
// LSB-first digit-serial two's-complement adder/subtractor with per-word framing checks.
// Define DIGIT_SERIAL_ADD_SUB_OVF_EN to build signed-overflow detection; otherwise out_ovf is 0.
module digit_serial_add_sub #(
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned MAX_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    digit_serial_add_sub_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1) + 1;
    localparam int unsigned SUM_W = DIGIT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_DIGITS);

    typedef enum logic {IDLE, IN_WORD} state_t;

    state_t             state;
    logic               carry;
    logic               sub_q;
    logic               err_q;
    logic [CNT_W-1:0]   digit_cnt;

    logic               first_eff;
    logic               sub_eff;
    logic               cin;
    logic [DIGIT_W-1:0] b_x;
    logic [SUM_W-1:0]   sum_full;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               err_nxt;
    logic               ovf_c;

    // A digit arriving with no open word is treated as the start of one, flagged as an error.
    always_comb begin
        first_eff = bus.in_first | (state == IDLE);
        sub_eff   = first_eff ? bus.in_sub : sub_q;
        cin       = first_eff ? bus.in_sub : carry;
        b_x       = bus.in_b ^ {DIGIT_W{sub_eff}};
        sum_full  = SUM_W'(bus.in_a) + SUM_W'(b_x) + SUM_W'(cin);
        if (first_eff) begin
            cnt_nxt = CNT_W'(1);
        end else if (digit_cnt == CNT_MAX) begin
            cnt_nxt = digit_cnt;
        end else begin
            cnt_nxt = digit_cnt + CNT_W'(1);
        end
        err_nxt = (first_eff ? (~bus.in_first & (state == IDLE)) : err_q)
                  | (cnt_nxt > CNT_LIMIT);
`ifdef DIGIT_SERIAL_ADD_SUB_OVF_EN
        // Carry into the MSB recovered from the MSB sum bit, then XORed with the carry out.
        ovf_c = bus.in_a[DIGIT_W-1] ^ b_x[DIGIT_W-1] ^ sum_full[DIGIT_W-1] ^ sum_full[DIGIT_W];
`else
        ovf_c = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            carry         <= 1'b0;
            sub_q         <= 1'b0;
            err_q         <= 1'b0;
            digit_cnt     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_carry <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.out_err   <= 1'b0;
        end else if (bus.in_valid) begin
            sub_q         <= sub_eff;
            digit_cnt     <= cnt_nxt;
            err_q         <= err_nxt;
            bus.out_valid <= 1'b1;
            bus.out_last  <= bus.in_last;
            bus.out_sum   <= sum_full[DIGIT_W-1:0];
            bus.out_carry <= bus.in_last & sum_full[DIGIT_W];
            bus.out_ovf   <= bus.in_last & ovf_c;
            bus.out_err   <= bus.in_last & err_nxt;
            if (bus.in_last) begin
                state <= IDLE;
                carry <= 1'b0;
            end else begin
                state <= IN_WORD;
                carry <= sum_full[DIGIT_W];
            end
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_carry <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.out_err   <= 1'b0;
        end
    end
endmodule
